// File: rtl/axi_mem_tester_pkg.sv
// axi_mem_tester_pkg: shared FSM states and beat geometry for the AMCI pattern tester.
package axi_mem_tester_pkg;
    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, FINISH} state_t;
    localparam int WORD_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 512;
    localparam int BEAT_BYTES = DEFAULT_DATA_WIDTH / 8;
    localparam int WORDS_PER_BEAT = DEFAULT_DATA_WIDTH / WORD_WIDTH;
    function automatic int beat_bytes(input int dw);
        return dw / 8;
    endfunction
    function automatic int words_per_beat(input int dw);
        return dw / WORD_WIDTH;
    endfunction
endpackage

// File: rtl/mem_pattern_gen.sv
// mem_pattern_gen: expected beat i, word k = seed + i*words_per_beat + k (mod 2^32).
module mem_pattern_gen
    import axi_mem_tester_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int CNT_WIDTH  = 32
) (
    input  logic [WORD_WIDTH-1:0] seed,
    input  logic [CNT_WIDTH-1:0]  beat,
    output logic [DATA_WIDTH-1:0] pattern
);
    localparam int W = words_per_beat(DATA_WIDTH);
    logic [WORD_WIDTH-1:0] first;
    assign first = seed + WORD_WIDTH'(beat) * WORD_WIDTH'(W);
    for (genvar k = 0; k < W; k++) begin : g_w
        assign pattern[k*WORD_WIDTH +: WORD_WIDTH] = first + WORD_WIDTH'(k);
    end
endmodule

// File: rtl/axi_mem_pattern_tester.sv
// axi_mem_pattern_tester: writes a seeded pattern over a beat range via AMCI, reads it back and compares.
// Build option MEM_TESTER_ABORT_ON_ERROR_EN stops at the first miscompare or nonzero response.
module axi_mem_pattern_tester
    import axi_mem_tester_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 34,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  beat_count,
    input  logic [31:0]           seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_WIDTH-1:0]  error_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  axi_err,
    output logic [ADDR_WIDTH-1:0] amci_waddr,
    output logic [DATA_WIDTH-1:0] amci_wdata,
    output logic                  amci_write,
    input  logic                  amci_widle,
    input  logic [1:0]            amci_wresp,
    output logic [ADDR_WIDTH-1:0] amci_raddr,
    output logic                  amci_read,
    input  logic                  amci_ridle,
    input  logic [DATA_WIDTH-1:0] amci_rdata,
    input  logic [1:0]            amci_rresp
);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(beat_bytes(DATA_WIDTH));
`ifdef MEM_TESTER_ABORT_ON_ERROR_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif
    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q, addr;
    logic [CNT_WIDTH-1:0]  cnt, i;
    logic [31:0]           seed_q;
    logic [DATA_WIDTH-1:0] expected;
    logic                  last, miss, wbad, rbad;
    mem_pattern_gen #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_gen (
        .seed(seed_q), .beat(i), .pattern(expected)
    );
    assign last = i == cnt - CNT_WIDTH'(1);
    assign miss = amci_rdata != expected;
    assign wbad = amci_wresp != 2'b00;
    assign rbad = amci_rresp != 2'b00;
    // The *_WAIT states skip the request cycle itself, so widle/ridle is only trusted once the master has seen it.
    always_ff @(posedge M_AXI_ACLK) begin
        if (!resetn) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            error_count    <= '0;
            first_err_addr <= '0;
            axi_err        <= 1'b0;
            amci_write     <= 1'b0;
            amci_read      <= 1'b0;
            amci_waddr     <= '0;
            amci_raddr     <= '0;
            amci_wdata     <= '0;
            base_q         <= '0;
            addr           <= '0;
            cnt            <= '0;
            i              <= '0;
            seed_q         <= '0;
        end else begin
            done       <= 1'b0;
            amci_write <= 1'b0;
            amci_read  <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start && !busy) begin
                        base_q         <= base_addr & ~(STEP - ADDR_WIDTH'(1));
                        addr           <= base_addr & ~(STEP - ADDR_WIDTH'(1));
                        cnt            <= beat_count;
                        seed_q         <= seed;
                        i              <= '0;
                        error_count    <= '0;
                        first_err_addr <= '0;
                        axi_err        <= 1'b0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        state          <= beat_count == '0 ? FINISH : WR_ISSUE;
                    end
                end
                WR_ISSUE: if (amci_widle) begin
                    amci_waddr <= addr;
                    amci_wdata <= expected;
                    amci_write <= 1'b1;
                    state      <= WR_WAIT;
                end
                WR_WAIT: if (!amci_write && amci_widle) begin
                    axi_err <= axi_err | wbad;
                    addr    <= last ? base_q : addr + STEP;
                    i       <= last ? '0 : i + CNT_WIDTH'(1);
                    state   <= ABORT && wbad ? FINISH : last ? RD_ISSUE : WR_ISSUE;
                end
                RD_ISSUE: if (amci_ridle) begin
                    amci_raddr <= addr;
                    amci_read  <= 1'b1;
                    state      <= RD_WAIT;
                end
                RD_WAIT: if (!amci_read && amci_ridle) begin
                    axi_err <= axi_err | rbad;
                    if (miss) begin
                        error_count <= &error_count ? error_count : error_count + CNT_WIDTH'(1);
                        if (error_count == '0) first_err_addr <= addr;
                    end
                    addr  <= addr + STEP;
                    i     <= i + CNT_WIDTH'(1);
                    state <= (ABORT && (miss || rbad)) || last ? FINISH : RD_ISSUE;
                end
                FINISH: begin
                    done  <= 1'b1;
                    pass  <= error_count == '0 && !axi_err;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mem_pattern_tester.sv
// tb_axi_mem_pattern_tester: scoreboard bench with a delay-capable AMCI memory model and fault injection.
`timescale 1ns/1ps
module tb_axi_mem_pattern_tester;
    localparam int DW = 512, AW = 34, CW = 32;
`ifdef MEM_TESTER_ABORT_ON_ERROR_EN
    localparam bit ABT = 1'b1;
`else
    localparam bit ABT = 1'b0;
`endif
    logic          clk = 1'b0, resetn = 1'b0, start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] beat_count = '0;
    logic [31:0]   seed = '0;
    logic          busy, done, pass, axi_err, amci_write, amci_read;
    logic [CW-1:0] error_count;
    logic [AW-1:0] first_err_addr, amci_waddr, amci_raddr;
    logic [DW-1:0] amci_wdata, amci_rdata;
    logic          amci_widle, amci_ridle;
    logic [1:0]    amci_wresp, amci_rresp;
    always #5 clk = ~clk;
    axi_mem_pattern_tester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .M_AXI_ACLK(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
        .beat_count(beat_count), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .error_count(error_count), .first_err_addr(first_err_addr), .axi_err(axi_err),
        .amci_waddr(amci_waddr), .amci_wdata(amci_wdata), .amci_write(amci_write),
        .amci_widle(amci_widle), .amci_wresp(amci_wresp), .amci_raddr(amci_raddr),
        .amci_read(amci_read), .amci_ridle(amci_ridle), .amci_rdata(amci_rdata),
        .amci_rresp(amci_rresp)
    );
    int passed = 0, total = 0, nwr = 0, nrd = 0;
    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    function automatic logic [DW-1:0] pat(input logic [31:0] sd, input int b);
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = sd + 32'(b * (DW / 32) + k);
        return v;
    endfunction
    logic [AW-1:0] cur_base = '0;
    int corrupt_beat = -1, bresp_beat = -1;
    bit rand_dly = 1'b0;
    function automatic int beat_of(input logic [AW-1:0] a);
        logic [AW-1:0] d;
        d = (a - cur_base) >> 6;
        return int'(d);
    endfunction
    logic [DW-1:0] mem [8];
    int wdly, rdly;
    always @(posedge clk) begin
        if (!resetn) begin
            amci_widle <= 1'b1;
            amci_ridle <= 1'b1;
            amci_wresp <= 2'd0;
            amci_rresp <= 2'd0;
            amci_rdata <= '0;
            wdly <= 0;
            rdly <= 0;
        end else begin
            if (amci_write) begin
                mem[beat_of(amci_waddr) & 7] <= amci_wdata;
                amci_widle <= 1'b0;
                amci_wresp <= beat_of(amci_waddr) == bresp_beat ? 2'd2 : 2'd0;
                wdly <= rand_dly ? int'($urandom_range(7)) : 0;
            end else if (!amci_widle) begin
                if (wdly == 0) amci_widle <= 1'b1;
                else wdly <= wdly - 1;
            end
            if (amci_read) begin
                amci_rdata <= mem[beat_of(amci_raddr) & 7] ^ DW'(beat_of(amci_raddr) == corrupt_beat);
                amci_ridle <= 1'b0;
                amci_rresp <= 2'd0;
                rdly <= rand_dly ? int'($urandom_range(7)) : 0;
            end else if (!amci_ridle) begin
                if (rdly == 0) amci_ridle <= 1'b1;
                else rdly <= rdly - 1;
            end
        end
    end
    logic [AW-1:0] wa_q[$], ra_q[$];
    logic [DW-1:0] wd_q[$];
    logic [31:0]   w_word0[$];
    always @(negedge clk) begin
        if (resetn && (amci_write || amci_read)) check("wr_rd_exclusive", DW'(amci_write & amci_read), DW'(0));
        if (resetn && amci_write) begin
            nwr++;
            w_word0.push_back(amci_wdata[31:0]);
            check("write_expected", DW'(wa_q.size() != 0), DW'(1));
            if (wa_q.size() != 0) begin
                check("waddr", DW'(amci_waddr), DW'(wa_q.pop_front()));
                check("wdata", amci_wdata, wd_q.pop_front());
            end
        end
        if (resetn && amci_read) begin
            nrd++;
            check("read_expected", DW'(ra_q.size() != 0), DW'(1));
            if (ra_q.size() != 0) check("raddr", DW'(amci_raddr), DW'(ra_q.pop_front()));
        end
    end
    task automatic load(input logic [AW-1:0] base, input logic [31:0] sd, input int nw, input int nr);
        logic [AW-1:0] ab;
        ab = base & ~AW'(63);
        cur_base = ab;
        wa_q.delete();
        wd_q.delete();
        ra_q.delete();
        w_word0.delete();
        for (int b = 0; b < nw; b++) begin
            wa_q.push_back(ab + AW'(b * 64));
            wd_q.push_back(pat(sd, b));
        end
        for (int b = 0; b < nr; b++) ra_q.push_back(ab + AW'(b * 64));
    endtask
    task automatic run(input logic [AW-1:0] base, input logic [CW-1:0] cnt, input logic [31:0] sd,
                       input int nw, input int nr, input logic [CW-1:0] exp_err,
                       input logic [AW-1:0] exp_first, input bit exp_axi, input bit poke);
        int w0, r0, k;
        bit exp_pass;
        exp_pass = exp_err == '0 && !exp_axi;
        load(base, sd, nw, nr);
        w0 = nwr;
        r0 = nrd;
        base_addr = base;
        beat_count = cnt;
        seed = sd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", DW'(busy), DW'(1));
        k = 0;
        while (!amci_write && !done && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("first_req_latency", DW'(k), DW'(1));
        if (poke) begin
            base_addr = '0;
            beat_count = 1;
            seed = 32'hdead_beef;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (!done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", DW'(done), DW'(1));
        check("busy_at_done", DW'(busy), DW'(1));
        check("pass", DW'(pass), DW'(exp_pass));
        check("error_count", DW'(error_count), DW'(exp_err));
        check("first_err_addr", DW'(first_err_addr), DW'(exp_first));
        check("axi_err", DW'(axi_err), DW'(exp_axi));
        check("write_count", DW'(nwr - w0), DW'(nw));
        check("read_count", DW'(nrd - r0), DW'(nr));
        @(negedge clk);
        check("done_one_cycle", DW'(done), DW'(0));
        check("busy_dropped", DW'(busy), DW'(0));
        check("pass_held", DW'(pass), DW'(exp_pass));
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        int k;
        repeat (3) @(negedge clk);
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_done", DW'(done), DW'(0));
        check("rst_pass", DW'(pass), DW'(0));
        check("rst_error_count", DW'(error_count), DW'(0));
        check("rst_first_err_addr", DW'(first_err_addr), DW'(0));
        check("rst_axi_err", DW'(axi_err), DW'(0));
        check("rst_write", DW'(amci_write), DW'(0));
        check("rst_read", DW'(amci_read), DW'(0));
        check("rst_wdata", amci_wdata, DW'(0));
        resetn = 1'b1;
        @(negedge clk);
        run(34'h1000, 4, 32'h1234_5678, 4, 4, 0, 0, 1'b0, 1'b0);
        check("beat1_word0", DW'(w_word0.size() > 1 ? w_word0[1] : 32'h0), DW'(32'h1234_5688));
        corrupt_beat = 2;
        run(34'h1000, 4, 32'hcafe_0001, 4, ABT ? 3 : 4, 1, 34'h1080, 1'b0, 1'b0);
        corrupt_beat = -1;
        bresp_beat = 0;
        run(34'h2000, 4, 32'h0bad_f00d, ABT ? 1 : 4, ABT ? 0 : 4, 0, 0, 1'b1, 1'b0);
        bresp_beat = -1;
        run(34'h3000, 0, 32'h1111_2222, 0, 0, 0, 0, 1'b0, 1'b0);
        rand_dly = 1'b1;
        run(34'h3_ffff_ff80, 4, 32'hffff_fff0, 4, 4, 0, 0, 1'b0, 1'b1);
        check("wrap_beat2_word0", DW'(w_word0.size() > 2 ? w_word0[2] : 32'h0), DW'(32'h0000_0010));
        corrupt_beat = 3;
        run(34'h3_ffff_ff95, 4, 32'h5555_aaaa, 4, 4, 1, 34'h40, 1'b0, 1'b0);
        corrupt_beat = -1;
        rand_dly = 1'b0;
        load(34'h4000, 32'h7777_0000, 4, 4);
        base_addr = 34'h4000;
        beat_count = 4;
        seed = 32'h7777_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!amci_read && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rd_seen_before_reset", DW'(amci_read), DW'(1));
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("reset_busy", DW'(busy), DW'(0));
        check("reset_read", DW'(amci_read), DW'(0));
        check("reset_done", DW'(done), DW'(0));
        resetn = 1'b1;
        @(negedge clk);
        run(34'h4000, 4, 32'h7777_0000, 4, 4, 0, 0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
